// File: rtl/pc_call_ctrl.sv
// pc_call_ctrl: program counter and call/return sequencer.
// Drives the push/pop side of a hardware return-address stack, executes
// CALL/RET/JUMP/increment in RUN, waits one cycle for popped data in
// RET_WAIT, and traps stack overflow/underflow into a halted FAULT state.
module pc_call_ctrl #(
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              call,
  input  logic              ret,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              stack_push,
  output logic              stack_pop,
  output logic [ADDR_W-1:0] stack_din,
  input  logic [ADDR_W-1:0] stack_dout,
  input  logic              stack_full,
  input  logic              stack_empty
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_RET_WAIT = 2'd1,
    S_FAULT    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              push_req;
  logic              pop_req;
  logic              ovf_set;
  logic              unf_set;

  // Sequential successor of an address; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] v);
    return v + ADDR_W'(1);
  endfunction

  // State, PC and sticky error flags; reset acts immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_RUN;
      pc            <= RESET_PC;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ovf_set) overflow_err  <= 1'b1;
      if (unf_set) underflow_err <= 1'b1;
    end
  end

  // Next-state, next-PC and stack request decode; ret > call > jump > inc.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    case (state)
      S_RUN: begin
        if (en) begin
          if (ret) begin
            // PC holds; the popped address arrives on stack_dout next cycle.
            if (!stack_empty) begin
              pop_req   = 1'b1;
              state_nxt = S_RET_WAIT;
            end else begin
              unf_set   = 1'b1;
              state_nxt = S_FAULT;
            end
          end else if (call) begin
            if (!stack_full) begin
              push_req = 1'b1;
              pc_nxt   = target;
            end else begin
              ovf_set   = 1'b1;
              state_nxt = S_FAULT;
            end
          end else if (jump) begin
            pc_nxt = target;
          end else begin
            pc_nxt = pc_inc(pc);
          end
        end
      end
      S_RET_WAIT: begin
        // All requests ignored; load the popped return address.
        pc_nxt    = stack_dout;
        state_nxt = S_RUN;
      end
      S_FAULT: begin
        // Halted until reset.
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_FAULT;
      end
    endcase
  end

  // Strobes are suppressed while reset is asserted so the stack sees no
  // spurious request during an asynchronous reset.
  always_comb begin
    stack_push = push_req & ~reset;
    stack_pop  = pop_req & ~reset;
    stack_din  = pc_inc(pc);
    busy       = (state == S_RET_WAIT);
    fault      = (state == S_FAULT);
  end

endmodule

// File: tb/tb_pc_call_ctrl.sv
// Directed self-checking bench for pc_call_ctrl with a small behavioural
// return-address stack (depth 4) connected to the stack interface.
module tb_pc_call_ctrl;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              en, call, ret, jump;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc;
  logic              busy, fault, overflow_err, underflow_err;
  logic              stack_push, stack_pop;
  logic [ADDR_W-1:0] stack_din;
  logic [ADDR_W-1:0] stack_dout;
  logic              stack_full, stack_empty;

  logic [ADDR_W-1:0] mem [DEPTH];
  int                sp;
  logic              force_full;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_call_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(4'h0)) dut (
    .clk(clk), .reset(reset), .en(en), .call(call), .ret(ret), .jump(jump),
    .target(target), .pc(pc), .busy(busy), .fault(fault),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .stack_push(stack_push), .stack_pop(stack_pop), .stack_din(stack_din),
    .stack_dout(stack_dout), .stack_full(stack_full), .stack_empty(stack_empty)
  );

  // Behavioural stack sharing the controller's reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp         <= 0;
      stack_dout <= '0;
    end else if (stack_push && sp < DEPTH) begin
      mem[sp] <= stack_din;
      sp      <= sp + 1;
    end else if (stack_pop && sp > 0) begin
      stack_dout <= mem[sp-1];
      sp         <= sp - 1;
    end
  end
  assign stack_full  = (sp == DEPTH) || force_full;
  assign stack_empty = (sp == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; call = 1'b0; ret = 1'b0; jump = 1'b0;
    target = '0; force_full = 1'b0;
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_push", stack_push, 0);
    chk("rst_pop", stack_pop, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_unf", underflow_err, 0);
    @(negedge clk); reset = 1'b0;

    // Increment 0 -> 1 -> 2 -> 3
    en = 1'b1;
    tick(); chk("inc1", pc, 1);
    tick(); chk("inc2", pc, 2);
    tick(); chk("inc3", pc, 3);

    // Wrap F -> 0
    jump = 1'b1; target = 4'hF;
    tick(); chk("jump_f", pc, 4'hF);
    jump = 1'b0;
    tick(); chk("wrap", pc, 0);

    // Single call/ret: from pc=2 call 9
    jump = 1'b1; target = 4'h2;
    tick(); chk("jump_2", pc, 2);
    jump = 1'b0; call = 1'b1; target = 4'h9; #1;
    chk("call_push", stack_push, 1);
    chk("call_din", stack_din, 3);
    chk("call_nopop", stack_pop, 0);
    tick(); chk("call_pc", pc, 9);
    call = 1'b0; ret = 1'b1; #1;
    chk("ret_pop", stack_pop, 1);
    chk("ret_nopush", stack_push, 0);
    tick(); chk("ret_busy", busy, 1);
    chk("ret_pc_hold", pc, 9);
    chk("ret_pop_once", stack_pop, 0);
    ret = 1'b0;
    tick(); chk("ret_pc", pc, 3);
    chk("ret_busy_clr", busy, 0);

    // Nested calls: pc=1 call 5, pc=5 call A
    jump = 1'b1; target = 4'h1;
    tick(); chk("jump_1", pc, 1);
    jump = 1'b0; call = 1'b1; target = 4'h5; #1;
    chk("n1_din", stack_din, 2);
    tick(); chk("n1_pc", pc, 5);
    target = 4'hA; #1;
    chk("n2_din", stack_din, 6);
    tick(); chk("n2_pc", pc, 4'hA);
    call = 1'b0; ret = 1'b1;
    tick(); chk("n_busy1", busy, 1);
    chk("n_wait_nopop", stack_pop, 0);   // ret held high is ignored in RET_WAIT
    tick(); chk("n_ret1_pc", pc, 6);
    #1; chk("n_ret2_pop", stack_pop, 1);
    tick(); chk("n_busy2", busy, 1);
    ret = 1'b0;
    tick(); chk("n_ret2_pc", pc, 2);
    chk("n_empty", stack_empty, 1);

    // Underflow trap
    ret = 1'b1; #1;
    chk("unf_nopop", stack_pop, 0);
    tick(); chk("unf_flag", underflow_err, 1);
    chk("unf_fault", fault, 1);
    chk("unf_pc", pc, 2);
    chk("unf_noovf", overflow_err, 0);
    ret = 1'b0; call = 1'b1; jump = 1'b1; target = 4'h7; #1;
    chk("flt_nopush", stack_push, 0);
    tick(); chk("flt_pc", pc, 2);
    chk("flt_sticky", fault, 1);
    call = 1'b0; jump = 1'b0;
    @(negedge clk); reset = 1'b1; #1;
    chk("flt_rst_pc", pc, 0);
    chk("flt_rst_fault", fault, 0);
    chk("flt_rst_unf", underflow_err, 0);
    @(negedge clk); reset = 1'b0; en = 1'b0;

    // Overflow trap
    force_full = 1'b1; en = 1'b1; call = 1'b1; target = 4'h9; #1;
    chk("ovf_nopush", stack_push, 0);
    tick(); chk("ovf_flag", overflow_err, 1);
    chk("ovf_fault", fault, 1);
    chk("ovf_pc", pc, 0);
    call = 1'b0; force_full = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("ovf_rst", overflow_err, 0);

    // call+ret: only the pop issues
    call = 1'b1; target = 4'h4;
    tick(); chk("cr_pc", pc, 4);
    ret = 1'b1; target = 4'h8; #1;
    chk("cr_pop", stack_pop, 1);
    chk("cr_nopush", stack_push, 0);
    tick(); chk("cr_busy", busy, 1);
    chk("cr_pc_hold", pc, 4);
    call = 1'b0; ret = 1'b0;

    // Async reset inside RET_WAIT
    #2; reset = 1'b1; #1;
    chk("rw_rst_pc", pc, 0);
    chk("rw_rst_busy", busy, 0);
    chk("rw_rst_pop", stack_pop, 0);
    @(negedge clk); reset = 1'b0;

    // en=0 with jump: pc holds
    en = 1'b0; jump = 1'b1; target = 4'h7;
    tick(); chk("en0_pc", pc, 0);
    tick(); chk("en0_pc2", pc, 0);
    jump = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
